// File: rtl/kv_write_fsm.sv
// Key vault write sequencer: copies an engine result into a vault entry one dword
// per granted cycle, then zero-fills the remainder of the entry.
module kv_write_fsm #(
    parameter int DATA_WIDTH      = 512,
    parameter int KV_ENTRY_DWORDS = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_b,
    input  logic                                  zeroize,
    input  logic                                  start,
    input  logic                                  allow,
    input  logic [$clog2(DATA_WIDTH/32):0]        num_dwords,
    input  logic                                  kv_wr_grant,
    output logic [$clog2(DATA_WIDTH/32)-1:0]      read_offset,
    output logic                                  kv_we,
    output logic [$clog2(KV_ENTRY_DWORDS)-1:0]    kv_offset,
    output logic                                  kv_zero,
    output logic                                  kv_last,
    output logic                                  ready,
    output logic                                  done,
    output logic [1:0]                            error_code
);

    localparam int SRC_DWORDS = DATA_WIDTH / 32;
    localparam int OFFSET_W   = $clog2(SRC_DWORDS);
    localparam int ENTRY_W    = $clog2(KV_ENTRY_DWORDS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] ZERO  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [OFFSET_W:0] SRC_LIMIT   = (OFFSET_W+1)'(SRC_DWORDS);
    localparam logic [ENTRY_W:0]  ENTRY_FULL  = (ENTRY_W+1)'(KV_ENTRY_DWORDS);
    localparam logic [ENTRY_W:0]  ENTRY_LAST  = (ENTRY_W+1)'(KV_ENTRY_DWORDS - 1);
    localparam logic [ENTRY_W:0]  OFF_ONE     = (ENTRY_W+1)'(1);

    logic [1:0]          state_q, state_d;
    logic [ENTRY_W:0]    offset_q, offset_d;
    logic [OFFSET_W:0]   len_q, len_d;
    logic [1:0]          err_q, err_d;

    logic                accept;
    logic [ENTRY_W:0]    len_ext;
    logic                data_last;
    logic                full_len;
    logic                zero_last;

    assign len_ext   = (ENTRY_W+1)'(len_q);
    assign data_last = (offset_q == len_ext - OFF_ONE);
    assign full_len  = (len_ext == ENTRY_FULL);
    assign zero_last = (offset_q == ENTRY_LAST);

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign kv_we       = (state_q == WRITE) || (state_q == ZERO);
    assign kv_zero     = (state_q == ZERO);
    assign kv_offset   = offset_q[ENTRY_W-1:0];
    assign read_offset = (state_q == WRITE) ? offset_q[OFFSET_W-1:0] : '0;
    assign error_code  = err_q;
    assign accept      = kv_we && kv_wr_grant;
    // Final write is either the last data dword of a full-length result or the last zero-fill dword.
    assign kv_last     = accept && (((state_q == WRITE) && data_last && full_len) ||
                                    ((state_q == ZERO) && zero_last));

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        len_d    = len_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = num_dwords;
                    offset_d = '0;
                    if (!allow) begin
                        err_d   = 2'd1;
                        state_d = DONE;
                    end else if ((num_dwords == '0) || (num_dwords > SRC_LIMIT)) begin
                        err_d   = 2'd2;
                        state_d = DONE;
                    end else begin
                        err_d   = 2'd0;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    if (data_last && full_len) begin
                        state_d  = DONE;
                        offset_d = '0;
                    end else begin
                        if (data_last) state_d = ZERO;
                        offset_d = offset_q + OFF_ONE;
                    end
                end
            end
            ZERO: begin
                if (accept) begin
                    if (zero_last) begin
                        state_d  = DONE;
                        offset_d = '0;
                    end else begin
                        offset_d = offset_q + OFF_ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (zeroize) begin
            state_d  = IDLE;
            offset_d = '0;
            len_d    = '0;
            err_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            offset_q <= '0;
            len_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            len_q    <= len_d;
            err_q    <= err_d;
        end
    end

endmodule
